// File: rtl/mem_slave_port_master.sv
// mem_slave_port_master: issues one read/write at a time on a selected channel of an HLS slave memory port.
// Optional: define MEM_SLAVE_PORT_MASTER_TIMEOUT_EN to give up on Sout_DataRdy after TIMEOUT wait cycles.
//
// state | meaning
// IDLE  | req_ready high, waiting for a request
// ISSUE | one-cycle read/write strobe on the selected channel
// WAIT  | address/size/data held, waiting for Sout_DataRdy of that channel
// RESP  | response presented until rsp_ready
module mem_slave_port_master #(
   parameter int CHANNELS = 2,
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int SIZE_W   = 4,
   parameter int TIMEOUT  = 1024,
   localparam int CHAN_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic                     req_we,
   input  logic [CHAN_W-1:0]        req_chan,
   input  logic [ADDR_W-1:0]        req_addr,
   input  logic [SIZE_W-1:0]        req_size,
   input  logic [DATA_W-1:0]        req_wdata,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [DATA_W-1:0]        rsp_rdata,
   output logic                     rsp_err,
   output logic [CHANNELS-1:0]        S_oe_ram,
   output logic [CHANNELS-1:0]        S_we_ram,
   output logic [CHANNELS*ADDR_W-1:0] S_addr_ram,
   output logic [CHANNELS*DATA_W-1:0] S_Wdata_ram,
   output logic [CHANNELS*SIZE_W-1:0] S_data_ram_size,
   input  logic [CHANNELS*DATA_W-1:0] Sout_Rdata_ram,
   input  logic [CHANNELS-1:0]        Sout_DataRdy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t                     state_q, state_d;
   logic                       we_q;
   logic [CHAN_W-1:0]          chan_q;
   logic [SIZE_W-1:0]          size_q;
   logic                       accept, illegal, rdy, timeout;
   logic [DATA_W-1:0]          rd_slice, rd_mask;
   logic [CHANNELS-1:0]        oe_d, we_d;
   logic [CHANNELS*ADDR_W-1:0] addr_d;
   logic [CHANNELS*DATA_W-1:0] wdata_d;
   logic [CHANNELS*SIZE_W-1:0] size_d;
   logic [DATA_W-1:0]          rdata_d;
   logic                       err_d;

   assign accept   = (state_q == IDLE) && req_ready && req_valid;
   assign illegal  = (req_size == '0) || (int'(req_size) > DATA_W) || (int'(req_chan) >= CHANNELS);
   assign rdy      = (state_q == WAIT) && Sout_DataRdy[chan_q];
   assign rd_slice = Sout_Rdata_ram[DATA_W*int'(chan_q) +: DATA_W];
   // Shifting an all-ones word left by size leaves the low size bits clear; size==DATA_W keeps all ones.
   assign rd_mask  = ~({DATA_W{1'b1}} << size_q);

`ifdef MEM_SLAVE_PORT_MASTER_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   logic [CNT_W-1:0] wait_cnt_q;

   assign timeout = (state_q == WAIT) && (wait_cnt_q == CNT_W'(TIMEOUT - 1));

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                wait_cnt_q <= '0;
      else if (state_q != WAIT)  wait_cnt_q <= '0;
      else if (!timeout)         wait_cnt_q <= wait_cnt_q + 1'b1;
   end
`else
   // Never times out; the comparison only keeps TIMEOUT referenced in this build.
   assign timeout = (TIMEOUT < 0);
`endif

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= IDLE;
         req_ready       <= 1'b0;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= 1'b0;
         S_oe_ram        <= '0;
         S_we_ram        <= '0;
         S_addr_ram      <= '0;
         S_Wdata_ram     <= '0;
         S_data_ram_size <= '0;
         we_q            <= 1'b0;
         chan_q          <= '0;
         size_q          <= '0;
      end else begin
         state_q         <= state_d;
         req_ready       <= (state_d == IDLE);
         rsp_valid       <= (state_d == RESP);
         rsp_rdata       <= rdata_d;
         rsp_err         <= err_d;
         S_oe_ram        <= oe_d;
         S_we_ram        <= we_d;
         S_addr_ram      <= addr_d;
         S_Wdata_ram     <= wdata_d;
         S_data_ram_size <= size_d;
         if (accept) begin
            we_q   <= req_we;
            chan_q <= req_chan;
            size_q <= req_size;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept) state_d = illegal ? RESP : ISSUE;
         ISSUE:   state_d = WAIT;
         WAIT:    if (rdy || timeout) state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      oe_d    = '0;
      we_d    = '0;
      addr_d  = S_addr_ram;
      wdata_d = S_Wdata_ram;
      size_d  = S_data_ram_size;
      rdata_d = rsp_rdata;
      err_d   = rsp_err;
      unique case (state_q)
         IDLE: if (accept) begin
            addr_d  = '0;
            wdata_d = '0;
            size_d  = '0;
            if (illegal) begin
               err_d   = 1'b1;
               rdata_d = '0;
            end else begin
               err_d = 1'b0;
               if (req_we) we_d[req_chan] = 1'b1;
               else        oe_d[req_chan] = 1'b1;
               addr_d[ADDR_W*int'(req_chan) +: ADDR_W]  = req_addr;
               wdata_d[DATA_W*int'(req_chan) +: DATA_W] = req_wdata;
               size_d[SIZE_W*int'(req_chan) +: SIZE_W]  = req_size;
            end
         end
         WAIT: if (rdy || timeout) begin
            addr_d  = '0;
            wdata_d = '0;
            size_d  = '0;
            err_d   = !rdy;
            rdata_d = (rdy && !we_q) ? (rd_slice & rd_mask) : '0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_slave_port_master.sv
// Cycle-level bench for mem_slave_port_master: per-transaction timeline model plus randomized traffic.
module tb_mem_slave_port_master;
   localparam int CH = 2, AW = 7, DW = 8, SW = 4, TO = 16;

   logic clock = 1'b0, reset = 1'b0;
   logic req_valid = 1'b0, req_ready, req_we = 1'b0;
   logic [0:0] req_chan = '0;
   logic [AW-1:0] req_addr = '0;
   logic [SW-1:0] req_size = '0;
   logic [DW-1:0] req_wdata = '0;
   logic rsp_valid, rsp_ready = 1'b0, rsp_err;
   logic [DW-1:0] rsp_rdata;
   logic [CH-1:0] S_oe_ram, S_we_ram;
   logic [CH*AW-1:0] S_addr_ram;
   logic [CH*DW-1:0] S_Wdata_ram;
   logic [CH*SW-1:0] S_data_ram_size;
   logic [CH*DW-1:0] Sout_Rdata_ram = '0;
   logic [CH-1:0] Sout_DataRdy = '0;

   mem_slave_port_master #(.CHANNELS(CH), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_chan(req_chan),
      .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram), .S_Wdata_ram(S_Wdata_ram),
      .S_data_ram_size(S_data_ram_size), .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy));

   always #5 clock = ~clock;

   int checks = 0, failures = 0;
   logic exp_ready = 1'b0, exp_rsp_valid = 1'b0, exp_err = 1'b0;
   logic [DW-1:0] exp_rdata = '0;
   logic [CH-1:0] exp_oe = '0, exp_we = '0;
   logic [CH*AW-1:0] exp_addr = '0;
   logic [CH*DW-1:0] exp_wdata = '0;
   logic [CH*SW-1:0] exp_size = '0;
   logic [DW-1:0] last_rdata = '0;
   logic last_err = 1'b0;
   int strobe_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clock) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      chk("S_oe_ram", 32'(S_oe_ram), 32'(exp_oe));
      chk("S_we_ram", 32'(S_we_ram), 32'(exp_we));
      chk("S_addr_ram", 32'(S_addr_ram), 32'(exp_addr));
      chk("S_Wdata_ram", 32'(S_Wdata_ram), 32'(exp_wdata));
      chk("S_data_ram_size", 32'(S_data_ram_size), 32'(exp_size));
      if (exp_rsp_valid) begin
         chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rdata));
         chk("rsp_err", 32'(rsp_err), 32'(exp_err));
         last_rdata = rsp_rdata;
         last_err   = rsp_err;
      end
      if (S_oe_ram != '0 || S_we_ram != '0) strobe_cnt++;
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic bg();
      Sout_Rdata_ram = (CH*DW)'($urandom);
      Sout_DataRdy   = CH'($urandom);
   endtask

   task automatic exp_idle();
      exp_ready = 1'b1; exp_rsp_valid = 1'b0;
      exp_oe = '0; exp_we = '0; exp_addr = '0; exp_wdata = '0; exp_size = '0;
   endtask

   task automatic exp_bus_clear();
      exp_oe = '0; exp_we = '0; exp_addr = '0; exp_wdata = '0; exp_size = '0;
   endtask

   // Present a request in the current idle cycle; for legal requests also run the strobe cycle,
   // leaving the bench at the start of the first wait cycle.
   task automatic start(input bit we, input int chan, input int addr, input int size, input int wdata);
      req_valid = 1'b1; req_we = we; req_chan = 1'(chan);
      req_addr = AW'(addr); req_size = SW'(size); req_wdata = DW'(wdata);
      bg();
      step();
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = AW'($urandom);
      req_size = SW'($urandom); req_wdata = DW'($urandom);
      bg();
      exp_ready = 1'b0;
      if (size != 0 && size <= DW) begin
         exp_bus_clear();
         if (we) exp_we[chan] = 1'b1; else exp_oe[chan] = 1'b1;
         exp_addr[chan*AW +: AW]  = AW'(addr);
         exp_wdata[chan*DW +: DW] = DW'(wdata);
         exp_size[chan*SW +: SW]  = SW'(size);
         Sout_DataRdy[chan] = 1'b1;
         step();
         exp_oe = '0; exp_we = '0;
      end
   endtask

   task automatic respond(input int rdata, input bit err, input int bp);
      exp_bus_clear();
      exp_rsp_valid = 1'b1; exp_rdata = DW'(rdata); exp_err = err;
      for (int k = 0; k <= bp; k++) begin
         bg();
         req_valid = 1'($urandom);
         rsp_ready = (k == bp);
         step();
      end
      rsp_ready = 1'b0; req_valid = 1'b0;
      exp_idle();
   endtask

   task automatic txn(input bit we, input int chan, input int addr, input int size, input int wdata,
                      input int d, input int src, input int bp);
      bit ill;
      int exp_r;
      ill = (size == 0 || size > DW);
      start(we, chan, addr, size, wdata);
      exp_r = 0;
      if (!ill) begin
         for (int j = 0; j <= d; j++) begin
            bg();
            req_valid = 1'($urandom);
            Sout_DataRdy[chan] = (j == d);
            if (j == d) Sout_Rdata_ram[chan*DW +: DW] = DW'(src);
            step();
         end
         exp_r = we ? 0 : (src & ((1 << size) - 1));
      end
      req_valid = 1'b0;
      respond(exp_r, ill, bp);
   endtask

   task automatic reset_pulse();
      #2;
      reset = 1'b0;
      #1;
      chk("async strobe drop", 32'({S_oe_ram, S_we_ram}), 32'd0);
      chk("async rsp_valid drop", 32'(rsp_valid), 32'd0);
      exp_bus_clear();
      exp_ready = 1'b0; exp_rsp_valid = 1'b0;
      req_valid = 1'b0;
      step(); step();
      reset = 1'b1;
      step();
      exp_idle();
      for (int i = 0; i < 4; i++) begin bg(); step(); end
   endtask

   initial begin
      bg();
      step(); step(); step();
      reset = 1'b1;
      step();
      exp_idle();
      step();

      strobe_cnt = 0;
      txn(1'b1, 0, 'h05, 8, 'hA5, 0, 0, 0);
      chk("write strobe cycles", 32'(strobe_cnt), 32'd1);
      chk("write rsp_err", 32'(last_err), 32'd0);

      txn(1'b0, 1, 'h10, 4, 0, 3, 'hF3, 1);
      chk("read ch1 rdata", 32'(last_rdata), 32'h03);

      strobe_cnt = 0;
      txn(1'b0, 0, 'h22, 9, 0, 0, 0, 0);
      txn(1'b1, 1, 'h33, 0, 'h77, 0, 0, 2);
      chk("illegal no strobe", 32'(strobe_cnt), 32'd0);
      chk("illegal rsp_err", 32'(last_err), 32'd1);

      txn(1'b0, 0, 'h7F, 8, 0, 1, 'h3C, 5);
      chk("backpressure rdata", 32'(last_rdata), 32'h3C);
      txn(1'b0, 1, 'h01, 1, 0, 0, 'hFF, 0);
      chk("size1 rdata", 32'(last_rdata), 32'h01);

      for (int n = 0; n < 40; n++) begin
         int sel, size, gap;
         sel  = $urandom_range(0, 9);
         size = (sel == 0) ? 0 : (sel == 1) ? $urandom_range(9, 15) : $urandom_range(1, 8);
         txn(1'($urandom), $urandom_range(0, 1), $urandom_range(0, 127), size, $urandom_range(0, 255),
             $urandom_range(0, 4), $urandom_range(0, 255), $urandom_range(0, 3));
         gap = $urandom_range(0, 2);
         for (int g = 0; g < gap; g++) begin bg(); step(); end
      end

      start(1'b0, 0, 'h44, 8, 0);
      bg(); Sout_DataRdy[0] = 1'b0;
      step();
      Sout_DataRdy[0] = 1'b0;
      reset_pulse();
      txn(1'b0, 0, 'h45, 8, 0, 0, 'h5A, 0);
      chk("post-reset read", 32'(last_rdata), 32'h5A);

      start(1'b0, 1, 'h12, 8, 0);
`ifdef MEM_SLAVE_PORT_MASTER_TIMEOUT_EN
      for (int j = 0; j < TO; j++) begin bg(); Sout_DataRdy[1] = 1'b0; step(); end
      respond(0, 1'b1, 0);
      chk("timeout rsp_err", 32'(last_err), 32'd1);
`else
      for (int j = 0; j < 1000; j++) begin bg(); Sout_DataRdy[1] = 1'b0; step(); end
      chk("no-timeout still waiting", 32'(rsp_valid), 32'd0);
      reset_pulse();
`endif
      txn(1'b1, 1, 'h0F, 8, 'hC3, 2, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/mem_slave_port_master.md
Name: mem_slave_port_master

Overview:
- Initiator for the slave memory port (S_oe_ram / S_we_ram / S_addr_ram / S_Wdata_ram / S_data_ram_size -> Sout_Rdata_ram / Sout_DataRdy) of an HLS-generated top module.
- Lets testbench or debug logic preload inputs into accelerator memory and read back results without a hierarchical peek.
- Serialises single read/write transactions from a valid/ready request channel onto one selected bus channel; returns data or status on a valid/ready response channel.

Parameters:
- CHANNELS, 2, number of slave-port channels concatenated on each bus signal.
- ADDR_W, 7, address bits per channel.
- DATA_W, 8, data bits per channel.
- SIZE_W, 4, access-size bits per channel (size in bits).
- TIMEOUT, 1024, maximum wait cycles for Sout_DataRdy (used only with the optional feature).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid&ready.
- req_we  in  1  1 = write, 0 = read.
- req_chan  in  $clog2(CHANNELS) (min 1)  target channel.
- req_addr  in  ADDR_W  byte address.
- req_size  in  SIZE_W  access size in bits.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_W  read data, masked to req_size bits; 0 for writes.
- rsp_err  out  1  1 = illegal size or timeout.
- S_oe_ram  out  CHANNELS  per-channel read strobe.
- S_we_ram  out  CHANNELS  per-channel write strobe.
- S_addr_ram  out  CHANNELS*ADDR_W  per-channel address; channel k at slice k.
- S_Wdata_ram  out  CHANNELS*DATA_W  per-channel write data.
- S_data_ram_size  out  CHANNELS*SIZE_W  per-channel size.
- Sout_Rdata_ram  in  CHANNELS*DATA_W  read data from DUT.
- Sout_DataRdy  in  CHANNELS  per-channel completion.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All S_* outputs 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
  - Wait counter 0.
- All outputs are registered. Non-selected channel slices of every S_* output are driven 0 at all times.
- IDLE:
  - req_ready=1.
  - On req_valid: latch we/chan/addr/size/wdata; req_ready drops the next cycle.
  - req_size==0, req_size>DATA_W, or req_chan>=CHANNELS -> go to RESP with rsp_err=1, rsp_rdata=0, no bus activity.
  - Otherwise -> ISSUE.
- ISSUE (exactly 1 cycle):
  - Assert S_oe_ram[chan] (read) or S_we_ram[chan] (write).
  - Drive the addr/size/wdata slices for that channel.
  - -> WAIT.
  - The strobe is a one-cycle pulse. Address, size and data stay held through WAIT until DataRdy.
- WAIT:
  - Sample Sout_DataRdy[chan] each cycle.
  - When high: capture Sout_Rdata_ram slice masked to size bits (reads), rsp_err=0, clear S_* outputs, -> RESP.
  - DataRdy in the same cycle as the ISSUE strobe is ignored; it is only honoured from WAIT onward.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable while valid.
  - On rsp_ready: rsp_valid=0 next cycle, -> IDLE.
- Latency with zero-wait DUT (DataRdy in first WAIT cycle):
  - Accept at cycle 0, strobe at cycle 1, DataRdy seen at cycle 2, rsp_valid at cycle 3.
  - A back-to-back request is accepted at the earliest one cycle after the rsp handshake.
- Only one transaction is outstanding; no pipelining.
- Width rule: mask = (1<<size)-1 computed at DATA_W+1 bits, so size==DATA_W gives all ones.
- Spurious DataRdy on a non-selected channel, or in IDLE/RESP: ignored.
- Reset mid-transaction: strobes drop immediately; the pending response is discarded.

Optional Feature:
- Macro MEM_SLAVE_PORT_MASTER_TIMEOUT_EN.
- Defined:
  - WAIT counts cycles from 0.
  - If the count reaches TIMEOUT-1 without DataRdy: clear S_* outputs, rsp_err=1, rsp_rdata=0, -> RESP.
  - Counter clears on entry to WAIT.
- Not defined:
  - No counter logic is synthesised; WAIT holds indefinitely.
  - rsp_err is set only for illegal size or channel.

Test Plan:
- Write ch0: req_we=1, addr=0x05, size=8, wdata=0xA5; DUT model asserts DataRdy[0] on the first WAIT cycle.
  -> S_we_ram=2'b01 for exactly 1 cycle; S_addr_ram[6:0]=0x05 and S_Wdata_ram[7:0]=0xA5 until DataRdy; ch1 slices 0; rsp_valid at cycle 3; rsp_err=0.
- Read ch1: addr=0x10, size=4; model returns Sout_Rdata_ram[15:8]=0xF3 after 3 wait cycles.
  -> S_oe_ram=2'b10 pulse; rsp_rdata=0x03; rsp_err=0.
- Illegal size: req_size=9 or 0.
  -> no S_* activity; rsp_valid with rsp_err=1, rsp_rdata=0, 1 cycle after accept.
- Backpressure: hold rsp_ready=0 for 5 cycles after a read returning 0x3C.
  -> rsp_valid and rsp_rdata=0x3C stable for all 5 cycles; req_ready=0 throughout; next request accepted only after the handshake.
- Reset asserted during WAIT.
  -> S_oe_ram/S_we_ram go 0 asynchronously; after release, state is IDLE with req_ready=1 and no response emitted.
- With MEM_SLAVE_PORT_MASTER_TIMEOUT_EN and TIMEOUT=16: DataRdy never asserted.
  -> rsp_err=1 after 16 WAIT cycles. Without the macro, rsp_valid is still 0 after 1000 cycles.
